// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector:
// default pattern, default widths and the legal pattern-length range.
package seq_det_pkg;

   localparam int          PAT_W_DEF   = 4;
   localparam int          CNT_W_DEF   = 8;
   localparam int          PAT_W_MIN   = 2;
   localparam int          PAT_W_MAX   = 32;
   localparam logic [31:0] PATTERN_DEF = 32'b1011;

   function automatic bit pat_w_ok(input int w);
      return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
   endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + W'(1);
   end

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern, overlap control and a
// saturating match counter. The serial input is seq_bit because "sequence" is an SV keyword.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = PAT_W_DEF,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF),
   parameter int               CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seq_bit,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             tick,
   output logic [CNT_W-1:0] match_count,
   output logic             armed
);

   localparam int               FILL_W  = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] ARM_LVL = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);

   if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
      $error("seq_det_param: PAT_W out of range");
   end

   logic [PAT_W-1:0]  pat_reg;
   logic [PAT_W-1:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;
   logic              accept;
   logic              match;
   logic              hist_unused;

   // The oldest history bit never reaches the compare window.
   assign hist_unused = hist[PAT_W-1];

   // A pattern load drops any bit offered in the same cycle.
   assign accept = in_valid && !pat_load;
   assign window = {hist[PAT_W-2:0], seq_bit};
   assign match  = accept && (fill >= ARM_LVL) && (window == pat_reg);
   assign armed  = (fill >= ARM_LVL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_reg <= PATTERN;
         hist    <= '0;
         fill    <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= match;
         if (pat_load) begin
            pat_reg <= pat_in;
            fill    <= '0;
         end else if (accept) begin
            hist <= window;
            // Non-overlapping mode forgets everything up to and including the match.
            if (match && !overlap)
               fill <= '0;
            else if (fill != FULL)
               fill <= fill + FILL_W'(1);
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (match),
      .clr (cnt_clr),
      .q   (match_count)
   );

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench: default instance plus a CNT_W=2 instance on shared stimulus.
module tb_seq_det_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       seq_bit, in_valid, overlap, pat_load, cnt_clr;
   logic [3:0] pat_in;
   logic       tick0, armed0, tick1, armed1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_det_param u_dut (
      .clk(clk), .rst(rst), .seq_bit(seq_bit), .in_valid(in_valid),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .tick(tick0), .match_count(cnt0), .armed(armed0)
   );

   seq_det_param #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .seq_bit(seq_bit), .in_valid(in_valid),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .tick(tick1), .match_count(cnt1), .armed(armed1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given bit offered; control strobes drop afterwards.
   task automatic step(input logic b, input logic v);
      seq_bit  = b;
      in_valid = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      pat_load = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [6:0]  bits7;
      logic [6:0]  exp7;
      logic [3:0]  bits4;
      logic [15:0] bits16;

      rst = 1'b1; seq_bit = 1'b0; in_valid = 1'b0; overlap = 1'b1;
      pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
      #2;
      chk("rst_tick", 32'(tick0), 32'h0);
      chk("rst_cnt", 32'(cnt0), 32'h0);
      chk("rst_armed", 32'(armed0), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Overlapping stream 1011011
      bits7 = 7'b1011011;
      exp7  = 7'b0001001;
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(bits7[6-i], 1'b1);
         chk($sformatf("ovl_tick%0d", i), 32'(tick0), 32'(exp7[6-i]));
      end
      chk("ovl_cnt", 32'(cnt0), 32'd2);

      // Same stream, non-overlapping
      rst_pulse();
      overlap = 1'b0;
      exp7 = 7'b0001000;
      for (int i = 0; i < 7; i++) begin
         step(bits7[6-i], 1'b1);
         chk($sformatf("novl_tick%0d", i), 32'(tick0), 32'(exp7[6-i]));
      end
      chk("novl_cnt", 32'(cnt0), 32'd1);
      chk("novl_armed", 32'(armed0), 32'h1);

      // Valid gaps of 3 idle cycles
      rst_pulse();
      overlap = 1'b1;
      bits4 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         step(bits4[3-i], 1'b1);
         chk($sformatf("gap_tick%0d", i), 32'(tick0), (i == 3) ? 32'h1 : 32'h0);
         for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0);
            chk($sformatf("gap_idle%0d_%0d", i, j), 32'(tick0), 32'h0);
         end
      end
      chk("gap_cnt", 32'(cnt0), 32'd1);

      // Pattern load over a partial history; offered bit is dropped
      rst_pulse();
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
      chk("load_pre_armed", 32'(armed0), 32'h1);
      pat_load = 1'b1; pat_in = 4'b0110;
      step(1'b1, 1'b1);
      chk("load_armed", 32'(armed0), 32'h0);
      chk("load_tick", 32'(tick0), 32'h0);
      bits4 = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         step(bits4[3-i], 1'b1);
         chk($sformatf("load_tick%0d", i), 32'(tick0), (i == 3) ? 32'h1 : 32'h0);
      end
      chk("load_cnt", 32'(cnt0), 32'd1);

      // Saturation: five overlapping matches
      rst_pulse();
      overlap = 1'b1;
      bits16 = 16'b1011011011011011;
      for (int i = 0; i < 16; i++) step(bits16[15-i], 1'b1);
      chk("sat_cnt2", 32'(cnt1), 32'd3);
      chk("sat_cnt8", 32'(cnt0), 32'd5);

      // Clear coinciding with a match
      step(1'b0, 1'b1); step(1'b1, 1'b1);
      cnt_clr = 1'b1;
      step(1'b1, 1'b1);
      chk("clr_tick", 32'(tick0), 32'h1);
      chk("clr_cnt8", 32'(cnt0), 32'h0);
      chk("clr_cnt2", 32'(cnt1), 32'h0);
      step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      chk("post_clr_cnt", 32'(cnt0), 32'd1);

      // Reset mid-stream
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
      chk("mid_tick", 32'(tick0), 32'h0);
      chk("mid_armed", 32'(armed0), 32'h1);
      rst = 1'b1;
      #2;
      chk("mid_rst_tick", 32'(tick0), 32'h0);
      chk("mid_rst_cnt", 32'(cnt0), 32'h0);
      chk("mid_rst_armed", 32'(armed0), 32'h0);
      chk("mid_rst_cnt2", 32'(cnt1), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b1, 1'b1);
      chk("after_rst_tick", 32'(tick0), 32'h0);
      chk("after_rst_armed", 32'(armed0), 32'h0);
      chk("after_rst_cnt", 32'(cnt0), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..32).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, pattern loaded at reset; MSB is compared against the oldest bit.
REQ-003 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-004 SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-005 Ports, one per line (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- rst  input  1  async active-high reset
- sequence  input  1  serial data bit
- in_valid  input  1  sequence is sampled this cycle
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- pat_load  input  1  load pat_in into the pattern register
- pat_in  input  PAT_W  new pattern
- cnt_clr  input  1  synchronous clear of match_count
- tick  output  1  registered one-cycle match pulse
- match_count  output  CNT_W  saturating count of matches
- armed  output  1  history holds at least PAT_W-1 valid bits

Function
REQ-006 SHALL shift sequence into history register hist (PAT_W bits, newest at LSB) only on clk edges with in_valid=1; hist SHALL hold otherwise.
REQ-007 SHALL keep fill counter fill (0..PAT_W, saturating), incremented on each accepted bit.
REQ-008 Match SHALL be true on an accepted bit when fill >= PAT_W-1 and {hist[PAT_W-2:0], sequence} == pat_reg.
REQ-009 tick SHALL be 1 for exactly the one cycle after the edge that accepted the matching bit (latency 1), and 0 otherwise.
REQ-010 With overlap=1, fill SHALL be unchanged by a match, so suffix bits may start the next match.
REQ-011 With overlap=0, fill SHALL be set to 0 on a match; hist still shifts but old bits are ignored.
REQ-012 overlap SHALL be sampled per accepted bit; changing it mid-stream SHALL affect only subsequent matches.
REQ-013 pat_load=1 SHALL load pat_reg from pat_in and set fill to 0.
REQ-014 pat_load SHALL take priority over in_valid in the same cycle: the bit is dropped and no match is evaluated.
REQ-015 match_count SHALL increment by 1 per match.
REQ-016 match_count SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-017 cnt_clr SHALL set match_count to 0, and SHALL win over a simultaneous match; tick still pulses.
REQ-018 armed SHALL equal (fill >= PAT_W-1), combinationally from registered state.

Reset
REQ-019 On rst=1, the block SHALL immediately set hist=0, fill=0, pat_reg=PATTERN, tick=0, match_count=0, armed=0.
REQ-020 Reset asserted mid-stream SHALL discard partial history; no tick SHALL be produced from bits accepted before reset.
REQ-021 The first edge after rst deasserts SHALL be able to accept a bit.

Structure
REQ-022 Package seq_det_pkg SHALL hold the default PATTERN, the default PAT_W and CNT_W constants, and the PAT_W range limits.
REQ-023 The match counter SHALL be a sub-module sat_counter (parameter W; inputs inc and clr; output q).
REQ-024 All outputs except armed SHALL be registered.

Verification
REQ-025 Overlap stream: overlap=1, default pattern, bits 1,0,1,1,0,1,1 each with in_valid=1 -> tick after bit 4 and bit 7; match_count=2.
REQ-026 Non-overlap stream: same bits with overlap=0 -> tick after bit 4 only; match_count=1.
REQ-027 Valid gaps: bits 1,0,1,1 with in_valid low for 3 cycles between each bit -> a single tick, one cycle after the edge accepting the last bit.
REQ-028 Pattern load: after 3 bits, pat_load with pat_in=4'b0110, then stream 0,1,1,0 -> tick once; armed=0 right after the load.
REQ-029 Saturation and clear: CNT_W=2, 5 overlapping matches -> match_count stays 3; cnt_clr coinciding with a match -> count 0 and tick=1.
REQ-030 Reset mid-operation: stream 1,0,1, assert rst for one cycle, then stream 1 -> no tick; all outputs at reset values during rst.
